// File: rtl/tx_iq_unpacker.sv
// Splits SPI IQ words into a byte stream for the dsiq FIFO, tagging channel index and frame end.
// Words arriving while the unpacker is busy or disabled are dropped and counted.
module tx_iq_unpacker #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NCH       = 1,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic [WORD_W-1:0] i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic [7:0]        o_m_tdata,
    output logic              o_m_tvalid,
    input  logic              i_m_tready,
    output logic              o_m_tlast,
    output logic [1:0]        o_m_tuser,
    output logic [CNT_W-1:0]  o_ovf_cnt,
    output logic              o_ovf_flag,
    input  logic              i_ovf_clr
);

    localparam int unsigned NB  = WORD_W / 8;
    localparam int unsigned BCW = $clog2(NB);

    typedef enum logic {StIdle, StShift} state_e;

    state_e             r_state;
    logic [WORD_W-1:0]  r_hold;
    logic [BCW-1:0]     r_byte_cnt;
    logic [1:0]         r_word_idx;
    logic [CNT_W-1:0]   r_ovf_cnt;
    logic               r_ovf_flag;

    logic               w_last_byte;
    logic               w_idx_last;
    logic [1:0]         w_idx_next;
    logic               w_accept;
    logic               w_in_ready;
    logic               w_load;
    logic               w_drop;
    logic [WORD_W-1:0]  w_shifted;

    assign w_last_byte = (r_byte_cnt == '0);
    assign w_idx_last  = (r_word_idx == 2'(NCH - 1));
    assign w_idx_next  = w_idx_last ? 2'd0 : r_word_idx + 2'd1;
    assign w_accept    = (r_state == StShift) & i_m_tready;

    // Ready also opens on the final accepted byte so the next word loads with no bubble.
    assign w_in_ready  = i_rst_n & i_enable &
                         ((r_state == StIdle) | (w_accept & w_last_byte));
    assign w_load      = i_in_valid & w_in_ready;
    assign w_drop      = i_in_valid & ~w_in_ready;
    assign w_shifted   = MSB_FIRST ? (r_hold << 8) : (r_hold >> 8);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_hold     <= '0;
            r_byte_cnt <= '0;
            r_word_idx <= 2'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_load) begin
                        r_hold     <= i_in_data;
                        r_byte_cnt <= BCW'(NB - 1);
                        r_state    <= StShift;
                    end else if (!i_enable) begin
                        r_word_idx <= 2'd0;
                    end
                end
                StShift: begin
                    if (w_accept) begin
                        if (w_last_byte) begin
                            r_word_idx <= w_idx_next;
                            if (w_load) begin
                                r_hold     <= i_in_data;
                                r_byte_cnt <= BCW'(NB - 1);
                            end else begin
                                r_state <= StIdle;
                            end
                        end else begin
                            r_hold     <= w_shifted;
                            r_byte_cnt <= r_byte_cnt - BCW'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Clear takes priority but a same-cycle drop still registers as the first new drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_cnt  <= '0;
            r_ovf_flag <= 1'b0;
        end else if (i_ovf_clr) begin
            r_ovf_cnt  <= w_drop ? CNT_W'(1) : '0;
            r_ovf_flag <= w_drop;
        end else if (w_drop) begin
            r_ovf_flag <= 1'b1;
            if (r_ovf_cnt != '1) begin
                r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
            end
        end
    end

    assign o_in_ready = w_in_ready;
    assign o_m_tvalid = (r_state == StShift);
    assign o_m_tdata  = MSB_FIRST ? r_hold[WORD_W-1 -: 8] : r_hold[7:0];
    assign o_m_tlast  = (r_state == StShift) & w_last_byte & w_idx_last;
    assign o_m_tuser  = r_word_idx;
    assign o_ovf_cnt  = r_ovf_cnt;
    assign o_ovf_flag = r_ovf_flag;

endmodule

// File: doc/tx_iq_unpacker.md
TX_IQ_UNPACKER -- requirements
Module: tx_iq_unpacker

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning input word width in bits; legal values are multiples of 8 from 16 to 64.
REQ-002 SHALL have parameter NCH, default 1, meaning words per frame (TX channels); legal range is 1..4.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning byte emission order: 1 = bits [WORD_W-1:WORD_W-8] first, 0 = bits [7:0] first.
REQ-004 SHALL have parameter CNT_W, default 16, meaning overflow counter width.
REQ-005 clk  in  1  single clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 enable  in  1  transmit gate (ptt | cwx).
REQ-008 in_data  in  WORD_W  received SPI IQ word.
REQ-009 in_valid  in  1  one-cycle word strobe, already synchronised to clk.
REQ-010 in_ready  out  1  unpacker can accept a word this cycle.
REQ-011 m_tdata  out  8  byte to the dsiq FIFO.
REQ-012 m_tvalid  out  1  byte valid.
REQ-013 m_tready  in  1  FIFO accepts the byte.
REQ-014 m_tlast  out  1  last byte of the last word of a frame.
REQ-015 m_tuser  out  2  channel index (0..NCH-1) of the current word.
REQ-016 ovf_cnt  out  CNT_W  saturating count of dropped words.
REQ-017 ovf_flag  out  1  sticky flag, set when any word has been dropped.
REQ-018 ovf_clr  in  1  synchronous clear of ovf_cnt and ovf_flag.

Function
REQ-019 SHALL implement states IDLE and SHIFT, with NB = WORD_W/8 bytes per word.
REQ-020 IDLE: in_ready = enable; m_tvalid = 0.
REQ-021 IDLE, in_valid & enable: capture in_data into the hold register; set byte_cnt = NB-1; move to SHIFT on the next cycle.
REQ-022 SHIFT: m_tvalid = 1; m_tdata = current end byte of the hold register per MSB_FIRST.
REQ-023 SHIFT, m_tvalid & m_tready: shift the hold register by 8 toward the emitting end and decrement byte_cnt.
REQ-024 SHIFT with m_tready = 0: m_tdata, m_tlast and m_tuser SHALL hold stable until accepted.
REQ-025 m_tlast = 1 only while byte_cnt = 0 and word index = NCH-1.
REQ-026 On accepting the byte with byte_cnt = 0: word index advances, wrapping NCH-1 -> 0.
REQ-027 On accepting the byte with byte_cnt = 0, in_ready SHALL also be 1 that cycle when enable = 1, combinationally from m_tready.
REQ-028 A word strobed on that same cycle loads directly into the hold register and the block stays in SHIFT, giving zero bubble between words.
REQ-029 Otherwise, on accepting the byte with byte_cnt = 0, the block returns to IDLE.
REQ-030 Byte throughput SHALL be 1 byte/cycle while m_tready = 1.
REQ-031 Latency from in_valid to first m_tvalid SHALL be 1 cycle.
REQ-032 m_tuser = word index of the word currently in SHIFT.
REQ-033 in_valid & !in_ready (busy or enable = 0) SHALL drop the word, set ovf_flag and increment ovf_cnt, saturating at all-ones.
REQ-034 ovf_clr and a drop on the same cycle: the clear wins, then the count is 1 and the flag is 1.
REQ-035 enable falling mid-word SHALL NOT truncate it; all NB bytes are emitted.
REQ-036 The word index SHALL reset to 0 whenever the block is in IDLE with enable = 0, so a new burst always starts on channel 0.
REQ-037 When NCH = 1, m_tlast SHALL accompany every word's final byte and m_tuser = 0.

Reset
REQ-038 rst_n low SHALL force IDLE, byte_cnt = 0, word index = 0, hold register = 0, m_tvalid = 0, m_tlast = 0, m_tuser = 0, ovf_cnt = 0, ovf_flag = 0, and in_ready = 0.
REQ-039 Reset asserted mid-word SHALL discard the partial word; no byte is emitted after release until a new in_valid.
REQ-040 Reset release SHALL take effect on the first rising clk edge after deassertion.

Verification
REQ-041 Defaults: enable = 1, m_tready = 1, in_data = 0x1234ABCD -> bytes 12,34,AB,CD on consecutive cycles; tlast on CD; tuser = 0.
REQ-042 NCH = 2, words 0x11223344 and 0x55667788 strobed back-to-back at the last byte -> 8 contiguous bytes; tuser 0,0,0,0,1,1,1,1; tlast only on 88.
REQ-043 m_tready low for 3 cycles at byte 2 -> m_tdata holds 0x34 and m_tvalid stays 1; no byte lost or duplicated.
REQ-044 in_valid strobed during byte 1 of a word -> word dropped, ovf_cnt = 1, ovf_flag = 1; ovf_clr -> both 0.
REQ-045 CNT_W = 4 with 20 drops -> ovf_cnt = 15 and stays there.
REQ-046 MSB_FIRST = 0, WORD_W = 16, in_data 0xBEEF -> EF then BE; rst_n pulsed after EF -> BE never appears and m_tvalid = 0.
